// File: rtl/serial_tx_arbiter_if.sv
// Requester/line bundle for the shared bit-serial sender.
// master = requester side, slave = arbiter side.
interface serial_tx_arbiter_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              gnt0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              gnt1;
    logic              tx_out;
    logic              busy;
    logic              active_src;

    modport master (
        output req0, data0, req1, data1,
        input  gnt0, gnt1, tx_out, busy, active_src
    );

    modport slave (
        input  req0, data0, req1, data1,
        output gnt0, gnt1, tx_out, busy, active_src
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one framed bit-serial transmitter
// (start, DATA_W bits LSB first, stop), DIVISOR clocks per bit.
module serial_tx_arbiter #(
    parameter int unsigned DIVISOR = 400,
    parameter int unsigned DATA_W  = 8
) (
    input logic          clock_in,
    input logic          reset,
    serial_tx_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(DIVISOR);
    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIVISOR - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   timer_q, timer_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              prio_q, prio_d;   // 1: requester 1 wins a tie
    logic              src_q, src_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              win;
    logic              period_end;

    assign period_end = (timer_q == CntLast);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        prio_d  = prio_q;
        src_d   = src_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        tx_d    = 1'b1;
        win     = 1'b0;

        if (state_q != StIdle) begin
            timer_d = period_end ? '0 : timer_q + CntW'(1);
        end

        // tx follows the state of the cycle just ending, so the line lags by one clock
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (bus.req0 || bus.req1) begin
                    win     = (bus.req0 && bus.req1) ? prio_q : bus.req1;
                    state_d = StStart;
                    timer_d = '0;
                    idx_d   = '0;
                    shift_d = win ? bus.data1 : bus.data0;
                    src_d   = win;
                    prio_d  = ~win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (period_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (period_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (period_end) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Stays high one cycle past STOP so it covers the delayed stop bit on tx
        busy_d = (state_d != StIdle) || (state_q != StIdle);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            prio_q  <= 1'b0;
            src_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            prio_q  <= prio_d;
            src_q   <= src_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.tx_out     = tx_q;
    assign bus.busy       = busy_q;
    assign bus.active_src = src_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: per-cycle reference model, line decoder,
// vector table, directed corner sequences, random traffic and a parameter sweep.
module tb_serial_tx_arbiter;
    localparam int Div = 4;
    localparam int W   = 8;
    localparam int F   = (W + 2) * Div;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_tx_arbiter_if #(.DATA_W(8))  bm ();
    serial_tx_arbiter_if #(.DATA_W(1))  bs ();
    serial_tx_arbiter_if #(.DATA_W(16)) bl ();

    serial_tx_arbiter #(.DIVISOR(4), .DATA_W(8)) u_main (
        .clock_in(clk), .reset(reset), .bus(bm));
    serial_tx_arbiter #(.DIVISOR(2), .DATA_W(1)) u_small (
        .clock_in(clk), .reset(reset), .bus(bs));
    serial_tx_arbiter #(.DIVISOR(400), .DATA_W(16)) u_large (
        .clock_in(clk), .reset(reset), .bus(bl));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: m_n counts clocks since the grant edge (0 = no frame on the line).
    int        m_n = 0;
    logic      m_last = 1'b1;  // last granted source; reset state lets req0 win a tie
    logic      m_act = 1'b0;
    logic [7:0] m_data = '0;
    logic      m_win;
    assign m_win = (bm.req0 && bm.req1) ? ~m_last : bm.req1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n    <= 0;
            m_last <= 1'b1;
            m_act  <= 1'b0;
        end else if ((m_n == 0 || m_n == F + 1) && (bm.req0 || bm.req1)) begin
            m_n    <= 1;
            m_last <= m_win;
            m_act  <= m_win;
            m_data <= m_win ? bm.data1 : bm.data0;
        end else if (m_n == F + 1) begin
            m_n <= 0;
        end else if (m_n != 0) begin
            m_n <= m_n + 1;
        end
    end

    // {gnt0, gnt1, busy, tx_out, active_src} the line should show this cycle
    function automatic logic [4:0] model_exp();
        logic tx;
        int   b;
        tx = 1'b1;
        if (m_n >= 2) begin
            b  = (m_n - 2) / Div;
            tx = (b == 0) ? 1'b0 : (b <= W) ? m_data[b-1] : 1'b1;
        end
        return {m_n == 1 && !m_act, m_n == 1 && m_act, m_n >= 1, tx, m_act};
    endfunction

    always @(negedge clk) begin
        chk("cycle_outputs", int'({bm.gnt0, bm.gnt1, bm.busy, bm.tx_out, bm.active_src}),
            int'(model_exp()));
    end

    // Line decoder: rebuilds frames from tx_out alone
    typedef struct {
        bit         ok;
        bit         src;
        logic [7:0] data;
    } rx_t;
    rx_t        rxq[$];
    int         rx_k = -1;
    logic [7:0] rx_byte = '0;
    logic       rx_src = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            rx_k <= -1;
        end else if (rx_k < 0) begin
            if (bm.tx_out == 1'b0) begin
                rx_k   <= 1;
                rx_src <= bm.active_src;
            end
        end else begin
            if (rx_k % Div == 2 && rx_k / Div >= 1 && rx_k / Div <= W) begin
                rx_byte[rx_k/Div-1] <= bm.tx_out;
            end
            if (rx_k == (W + 1) * Div + 2) begin
                rxq.push_back('{ok: bm.tx_out, src: rx_src, data: rx_byte});
                rx_k <= -1;
            end else begin
                rx_k <= rx_k + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        bm.req0 = 1'b0;
        bm.req1 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        rxq.delete();
    endtask

    // which: 0 -> gnt0, 1 -> gnt1, 2 -> either
    task automatic wait_gnt(input string name, input int which, output int at, output bit src);
        bit found;
        found = 1'b0;
        at    = -1;
        src   = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if ((which != 1 && bm.gnt0) || (which != 0 && bm.gnt1)) begin
                found = 1'b1;
                at    = cyc;
                src   = bm.gnt1;
            end
        end
        if (!found) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && bm.busy; i++) tick();
    endtask

    task automatic expect_rx(input string name, input bit src, input logic [7:0] d);
        rx_t r;
        for (int i = 0; i < 100 && rxq.size() == 0; i++) tick();
        if (rxq.size() == 0) begin
            chk({name, "_no_frame"}, 0, 1);
        end else begin
            r = rxq.pop_front();
            chk(name, int'({r.ok, r.src, r.data}), int'({1'b1, src, d}));
        end
    endtask

    function automatic logic [2:0] sw_sig(input int which);
        return (which == 0) ? {bs.gnt0, bs.busy, bs.tx_out} : {bl.gnt0, bl.busy, bl.tx_out};
    endfunction

    task automatic sweep(input int which, input int div, input int w, input logic [15:0] d);
        bit   found;
        int   k;
        int   bad;
        int   b;
        logic exp_tx;
        if (which == 0) begin
            bs.data0 = d[0];
            bs.req0  = 1'b1;
        end else begin
            bl.data0 = d;
            bl.req0  = 1'b1;
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = sw_sig(which)[2];
        end
        chk("sweep_gnt", int'(found), 1);
        bs.req0 = 1'b0;
        bl.req0 = 1'b0;
        k   = 0;
        bad = 0;
        for (int i = 0; i < (w + 2) * div + 10; i++) begin
            tick();
            if (!sw_sig(which)[1]) break;
            b      = k / div;
            exp_tx = (b == 0) ? 1'b0 : (b <= w) ? d[b-1] : 1'b1;
            if (sw_sig(which)[0] !== exp_tx) bad++;
            k++;
        end
        chk("sweep_frame_len", k, (w + 2) * div);
        chk("sweep_bits", bad, 0);
    endtask

    typedef struct {
        bit         r0;
        bit         r1;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         exp_src;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int   g0;
        int   g1;
        int   prev;
        int   cnt;
        bit   s;
        logic [7:0] v;

        vecs[0] = '{1, 0, 8'hA5, 8'h00, 0, 8'hA5};
        vecs[1] = '{0, 1, 8'h00, 8'h3C, 1, 8'h3C};
        vecs[2] = '{1, 1, 8'h11, 8'h22, 0, 8'h11};
        vecs[3] = '{1, 1, 8'h33, 8'h44, 1, 8'h44};
        vecs[4] = '{1, 1, 8'h55, 8'h66, 0, 8'h55};
        vecs[5] = '{0, 1, 8'h00, 8'h77, 1, 8'h77};
        vecs[6] = '{1, 1, 8'h88, 8'h99, 0, 8'h88};
        vecs[7] = '{1, 0, 8'h00, 8'h12, 0, 8'h00};
        vecs[8] = '{1, 1, 8'hFF, 8'h01, 1, 8'h01};

        bm.req0 = 1'b0; bm.req1 = 1'b0; bm.data0 = '0; bm.data1 = '0;
        bs.req0 = 1'b0; bs.req1 = 1'b0; bs.data0 = '0; bs.data1 = '0;
        bl.req0 = 1'b0; bl.req1 = 1'b0; bl.data0 = '0; bl.data1 = '0;
        tick();
        chk("reset_state", int'({bm.gnt0, bm.gnt1, bm.busy, bm.tx_out, bm.active_src}),
            int'(5'b00010));
        do_reset();

        // Vector table: round-robin order follows on from the reset pointer
        foreach (vecs[i]) begin
            bm.req0 = vecs[i].r0; bm.data0 = vecs[i].d0;
            bm.req1 = vecs[i].r1; bm.data1 = vecs[i].d1;
            wait_gnt("vec_gnt", 2, g0, s);
            bm.req0 = 1'b0;
            bm.req1 = 1'b0;
            chk("vec_winner", int'(s), int'(vecs[i].exp_src));
            expect_rx("vec_frame", vecs[i].exp_src, vecs[i].exp_data);
            wait_idle();
        end

        // Single frame: busy spans grant cycle through the delayed stop bit
        do_reset();
        bm.req0 = 1'b1; bm.data0 = 8'hA5;
        wait_gnt("single_gnt", 0, g0, s);
        bm.req0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200 && bm.busy; i++) begin
            cnt++;
            tick();
        end
        chk("single_busy_len", cnt, F + 1);
        expect_rx("single_frame", 1'b0, 8'hA5);

        // Async reset in the middle of the data bits
        do_reset();
        bm.req0 = 1'b1; bm.data0 = 8'h55;
        wait_gnt("rst_gnt", 0, g0, s);
        bm.req0 = 1'b0;
        repeat (15) tick();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset", int'({bm.gnt0, bm.gnt1, bm.busy, bm.tx_out}), int'(4'b0001));
        tick();
        tick();
        reset = 1'b0;
        rxq.delete();
        cnt = 0;
        repeat (50) begin
            tick();
            if (bm.tx_out !== 1'b1) cnt++;
        end
        chk("idle_after_reset", cnt, 0);
        chk("no_frame_after_reset", rxq.size(), 0);

        // Contention: both held, frames alternate back to back
        do_reset();
        bm.req0 = 1'b1; bm.data0 = 8'hC1;
        bm.req1 = 1'b1; bm.data1 = 8'hD2;
        prev = 0;
        for (int f = 0; f < 4; f++) begin
            wait_gnt("cont_gnt", 2, g0, s);
            chk("cont_order", int'(s), f % 2);
            if (f > 0) chk("cont_spacing", g0 - prev, F + 1);
            prev = g0;
            if (s) bm.data1 = bm.data1 + 8'd1;
            else   bm.data0 = bm.data0 + 8'd1;
        end
        bm.req0 = 1'b0;
        bm.req1 = 1'b0;
        wait_idle();
        expect_rx("cont_frame0", 1'b0, 8'hC1);
        expect_rx("cont_frame1", 1'b1, 8'hD2);

        // Request raised mid-frame waits for idle; data changed after grant is ignored
        do_reset();
        bm.req0 = 1'b1; bm.data0 = 8'hA5;
        wait_gnt("busy_gnt0", 0, g0, s);
        bm.req0 = 1'b0;
        repeat (10) tick();
        bm.req1 = 1'b1; bm.data1 = 8'h3C;
        wait_gnt("busy_gnt1", 1, g1, s);
        bm.data1 = 8'hFF;
        bm.req1  = 1'b0;
        chk("busy_gnt1_delay", g1 - g0, F + 1);
        expect_rx("busy_frame0", 1'b0, 8'hA5);
        expect_rx("busy_frame1", 1'b1, 8'h3C);
        wait_idle();

        // Withdrawn request: one-cycle req1 during busy never gets a grant
        do_reset();
        bm.req0 = 1'b1; bm.data0 = 8'h5A;
        wait_gnt("wd_gnt0", 0, g0, s);
        bm.req0 = 1'b0;
        repeat (10) tick();
        bm.req1 = 1'b1; bm.data1 = 8'h99;
        tick();
        bm.req1 = 1'b0;
        cnt = 0;
        repeat (80) begin
            tick();
            if (bm.gnt1) cnt++;
        end
        chk("wd_no_gnt1", cnt, 0);
        expect_rx("wd_frame", 1'b0, 8'h5A);
        chk("wd_single_frame", rxq.size(), 0);
        chk("wd_line_idle", int'({bm.busy, bm.tx_out}), int'(2'b01));

        // Random traffic against the per-cycle model
        do_reset();
        repeat (3000) begin
            tick();
            if (bm.req0 && bm.gnt0) begin
                bm.req0 = 1'b0; bm.data0 = 8'($urandom);
            end else if (bm.req0 && $urandom_range(0, 31) == 0) begin
                bm.req0 = 1'b0;
            end else if (!bm.req0 && $urandom_range(0, 15) == 0) begin
                bm.req0 = 1'b1; bm.data0 = 8'($urandom);
            end
            if (bm.req1 && bm.gnt1) begin
                bm.req1 = 1'b0; bm.data1 = 8'($urandom);
            end else if (bm.req1 && $urandom_range(0, 31) == 0) begin
                bm.req1 = 1'b0;
            end else if (!bm.req1 && $urandom_range(0, 15) == 0) begin
                bm.req1 = 1'b1; bm.data1 = 8'($urandom);
            end
        end
        bm.req0 = 1'b0;
        bm.req1 = 1'b0;
        wait_idle();

        // Parameter sweep on the extreme instances
        do_reset();
        sweep(0, 2, 1, 16'h0001);
        v = 8'($urandom);
        sweep(1, 400, 16, {v, 8'h6B});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
